// File: rtl/read_hit_controller_pkg.sv
// Shared cache package: read-sequencer states, hit-vector classes and address-field helpers.
package read_hit_controller_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    READ   = 3'd2,
    MISS   = 3'd3,
    RESP   = 3'd4
  } rd_state_e;

  typedef enum logic [1:0] {
    OH_NONE = 2'd0,
    OH_ONE  = 2'd1,
    OH_MANY = 2'd2
  } oh_class_e;

  localparam int DEF_ADDRESS_WIDTH = 32;
  localparam int DEF_INDEX_WIDTH   = 6;
  localparam int DEF_OFFSET_WIDTH  = 4;

  // Address layout, MSB to LSB: tag | index | offset.
  function automatic int tag_width(input int aw, input int iw, input int ow);
    return aw - iw - ow;
  endfunction

  function automatic int index_lsb(input int ow);
    return ow;
  endfunction

  function automatic int tag_lsb(input int iw, input int ow);
    return iw + ow;
  endfunction

endpackage

// File: rtl/onehot_checker.sv
// Classifies a hit vector as none / exactly one / many bits set using a balanced OR tree.
module onehot_checker
  import read_hit_controller_pkg::*;
#(
  parameter int WIDTH = 512
) (
  input  logic [WIDTH-1:0] i_vec,
  output oh_class_e        o_class
);

  localparam int LVL = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW  = 1 << LVL;

  logic [PW-1:0] w_pad;

  assign w_pad = PW'(i_vec);

  // Each tree node carries (any set, two-or-more set); pairs merge level by level in place.
  function automatic oh_class_e classify(input logic [PW-1:0] v);
    logic [PW-1:0] any_l;
    logic [PW-1:0] many_l;
    oh_class_e     res;
    any_l  = v;
    many_l = '0;
    for (int l = 0; l < LVL; l++) begin
      for (int i = 0; i < (PW >> (l + 1)); i++) begin
        many_l[i] = many_l[2*i] | many_l[2*i+1] | (any_l[2*i] & any_l[2*i+1]);
        any_l[i]  = any_l[2*i] | any_l[2*i+1];
      end
    end
    if (many_l[0])     res = OH_MANY;
    else if (any_l[0]) res = OH_ONE;
    else               res = OH_NONE;
    return res;
  endfunction

  assign o_class = classify(w_pad);

endmodule

// File: rtl/read_hit_controller.sv
// Sequences one CPU read through the cache: lookup, way read or refill/retry, response.
// Optional statistics counters are enabled by defining READ_STATS_EN.
module read_hit_controller
  import read_hit_controller_pkg::*;
#(
  parameter int NUM_WAYS      = 512,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int OFFSET_WIDTH  = DEF_OFFSET_WIDTH,
  parameter int INDEX_WIDTH   = DEF_INDEX_WIDTH,
  parameter int MAX_RETRY     = 2,
  localparam int TAG_W        = tag_width(ADDRESS_WIDTH, INDEX_WIDTH, OFFSET_WIDTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  output logic [TAG_W-1:0]         lookup_tag,
  output logic [INDEX_WIDTH-1:0]   lookup_index,
  input  logic [NUM_WAYS-1:0]      way_hit,
  output logic [NUM_WAYS-1:0]      target_way,
  output logic [OFFSET_WIDTH-1:0]  offset,
  input  logic [DATA_WIDTH-1:0]    read_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic                     rsp_error,
  output logic                     miss_valid,
  output logic [ADDRESS_WIDTH-1:0] miss_addr,
  input  logic                     miss_done,
`ifdef READ_STATS_EN
  input  logic                     stat_clr,
  output logic [31:0]              stat_hits,
  output logic [31:0]              stat_misses,
  output logic [31:0]              stat_errors,
`endif
  output rd_state_e                o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid is held until then.

  localparam int RETRY_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
  localparam logic [RETRY_W-1:0] LAST_TRY = RETRY_W'(MAX_RETRY - 1);

  rd_state_e                r_state;
  rd_state_e                w_state_nxt;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [NUM_WAYS-1:0]      r_hit;
  logic [RETRY_W-1:0]       r_retry;
  logic [DATA_WIDTH-1:0]    r_rsp_data;
  logic                     r_rsp_error;
  oh_class_e                w_hit_class;
  logic                     w_accept;
  logic                     w_take_hit;
  logic                     w_read_cap;
  logic                     w_err_rsp;
  logic                     w_retry_inc;
  logic                     w_enter_miss;

  onehot_checker #(.WIDTH(NUM_WAYS)) u_onehot (
    .i_vec   (way_hit),
    .o_class (w_hit_class)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_take_hit   = 1'b0;
    w_read_cap   = 1'b0;
    w_err_rsp    = 1'b0;
    w_retry_inc  = 1'b0;
    w_enter_miss = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = LOOKUP;
        end
      end
      LOOKUP: begin
        case (w_hit_class)
          OH_ONE: begin
            w_take_hit  = 1'b1;
            w_state_nxt = READ;
          end
          OH_NONE: begin
            w_enter_miss = 1'b1;
            w_state_nxt  = MISS;
          end
          default: begin
            w_err_rsp   = 1'b1;
            w_state_nxt = RESP;
          end
        endcase
      end
      READ: begin
        w_read_cap  = 1'b1;
        w_state_nxt = RESP;
      end
      MISS: begin
        if (miss_done) begin
          if (r_retry == LAST_TRY) begin
            w_err_rsp   = 1'b1;
            w_state_nxt = RESP;
          end else begin
            w_retry_inc = 1'b1;
            w_state_nxt = LOOKUP;
          end
        end
      end
      RESP: begin
        if (rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_hit       <= '0;
      r_retry     <= '0;
      r_rsp_data  <= '0;
      r_rsp_error <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr      <= req_addr;
        r_retry     <= '0;
        r_rsp_data  <= '0;
        r_rsp_error <= 1'b0;
      end
      if (w_take_hit)  r_hit   <= way_hit;
      if (w_retry_inc) r_retry <= r_retry + 1'b1;
      if (w_read_cap) begin
        r_rsp_data  <= read_data;
        r_rsp_error <= 1'b0;
      end
      if (w_err_rsp) begin
        r_rsp_data  <= '0;
        r_rsp_error <= 1'b1;
      end
    end
  end

  assign req_ready    = (r_state == IDLE);
  assign lookup_tag   = r_addr[tag_lsb(INDEX_WIDTH, OFFSET_WIDTH) +: TAG_W];
  assign lookup_index = r_addr[index_lsb(OFFSET_WIDTH) +: INDEX_WIDTH];
  assign offset       = r_addr[OFFSET_WIDTH-1:0];
  assign target_way   = (r_state == READ) ? r_hit : '0;
  assign miss_valid   = (r_state == MISS);
  assign miss_addr    = {r_addr[ADDRESS_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
  assign rsp_valid    = (r_state == RESP);
  assign rsp_data     = r_rsp_data;
  assign rsp_error    = r_rsp_error;
  assign o_dbg_state  = r_state;

`ifdef READ_STATS_EN
  logic [31:0] r_stat_hits;
  logic [31:0] r_stat_misses;
  logic [31:0] r_stat_errors;

  // Clear takes priority over any increment in the same cycle; counters saturate at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_hits   <= '0;
      r_stat_misses <= '0;
      r_stat_errors <= '0;
    end else if (stat_clr) begin
      r_stat_hits   <= '0;
      r_stat_misses <= '0;
      r_stat_errors <= '0;
    end else begin
      if (w_take_hit && (r_stat_hits != '1))     r_stat_hits   <= r_stat_hits + 32'd1;
      if (w_enter_miss && (r_stat_misses != '1)) r_stat_misses <= r_stat_misses + 32'd1;
      if (w_err_rsp && (r_stat_errors != '1))    r_stat_errors <= r_stat_errors + 32'd1;
    end
  end

  assign stat_hits   = r_stat_hits;
  assign stat_misses = r_stat_misses;
  assign stat_errors = r_stat_errors;
`endif

endmodule

// File: tb/tb_read_hit_controller.sv
// Randomized scoreboard bench for read_hit_controller with directed hit/miss/error/stall/reset cases.
module tb_read_hit_controller;
  import read_hit_controller_pkg::*;

  localparam int NW = 512;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int OW = 4;
  localparam int IW = 6;
  localparam int MR = 2;
  localparam int TW = AW - IW - OW;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [TW-1:0] lookup_tag;
  logic [IW-1:0] lookup_index;
  logic [NW-1:0] way_hit;
  logic [NW-1:0] target_way;
  logic [OW-1:0] offset;
  logic [DW-1:0] read_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_error;
  logic          miss_valid;
  logic [AW-1:0] miss_addr;
  logic          miss_done;
  rd_state_e     dbg_state;
`ifdef READ_STATS_EN
  logic          stat_clr;
  logic [31:0]   stat_hits;
  logic [31:0]   stat_misses;
  logic [31:0]   stat_errors;
  int            mdl_hits = 0;
  int            mdl_misses = 0;
  int            mdl_errs = 0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [DW:0]   exp_rsp_q[$];
  logic [AW-1:0] exp_miss_q[$];
  logic [NW-1:0] exp_tw_q[$];
  logic [NW-1:0] hv_q[$];
  logic          prev_miss = 1'b0;

  read_hit_controller #(
    .NUM_WAYS(NW), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW),
    .OFFSET_WIDTH(OW), .INDEX_WIDTH(IW), .MAX_RETRY(MR)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .lookup_tag   (lookup_tag),
    .lookup_index (lookup_index),
    .way_hit      (way_hit),
    .target_way   (target_way),
    .offset       (offset),
    .read_data    (read_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_error    (rsp_error),
    .miss_valid   (miss_valid),
    .miss_addr    (miss_addr),
    .miss_done    (miss_done),
`ifdef READ_STATS_EN
    .stat_clr     (stat_clr),
    .stat_hits    (stat_hits),
    .stat_misses  (stat_misses),
    .stat_errors  (stat_errors),
`endif
    .o_dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  function automatic logic [NW-1:0] bit_vec(input int b);
    logic [NW-1:0] v;
    v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  function automatic logic [NW-1:0] rand_hv(input int kind);
    logic [NW-1:0] v;
    int a;
    int b;
    v = '0;
    a = $urandom_range(0, NW - 1);
    b = (a + 1 + $urandom_range(0, NW - 2)) % NW;
    if (kind >= 1) v[a] = 1'b1;
    if (kind >= 2) v[b] = 1'b1;
    return v;
  endfunction

  // Reference model: walk the lookup attempts and apply the hit / multi-hit / refill-budget rules.
  task automatic model_txn(input logic [AW-1:0] addr, input logic [DW-1:0] rd,
                           output bit direct_hit);
    int refills;
    int a;
    int c;
    bit done;
    logic [NW-1:0] hv;
    refills = 0;
    a = 0;
    done = 0;
    direct_hit = 0;
    while (!done) begin
      hv = hv_q[(a < hv_q.size()) ? a : hv_q.size() - 1];
      c = $countones(hv);
      if (c == 1) begin
        exp_tw_q.push_back(hv);
        exp_rsp_q.push_back({1'b0, rd});
        direct_hit = (a == 0);
        done = 1;
`ifdef READ_STATS_EN
        mdl_hits++;
`endif
      end else if (c > 1) begin
        exp_rsp_q.push_back({1'b1, {DW{1'b0}}});
        done = 1;
`ifdef READ_STATS_EN
        mdl_errs++;
`endif
      end else begin
        exp_miss_q.push_back({addr[AW-1:OW], {OW{1'b0}}});
        refills++;
`ifdef READ_STATS_EN
        mdl_misses++;
`endif
        if (refills == MR) begin
          exp_rsp_q.push_back({1'b1, {DW{1'b0}}});
          done = 1;
`ifdef READ_STATS_EN
          mdl_errs++;
`endif
        end
      end
      a++;
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_txn(input logic [AW-1:0] addr, input logic [DW-1:0] rd,
                         input int stall, input bit poke);
    bit direct_hit;
    bit got_rsp;
    bit stable;
    int att;
    int cyc;
    int waited;
    logic [DW:0] er;
    model_txn(addr, rd, direct_hit);
    er = exp_rsp_q[exp_rsp_q.size() - 1];
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_addr  = addr;
    way_hit   = hv_q[0];
    read_data = rd;
    waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      fail_now("accept_timeout");
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    att = 0;
    cyc = 0;
    got_rsp = 0;
    while (!got_rsp && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("lookup_fields", {lookup_tag, lookup_index, offset}, addr);
      if (rsp_valid) begin
        got_rsp = 1;
        if (direct_hit) check("hit_latency", cyc, 3);
        stable = 1;
        for (int s = 0; s < stall; s++) begin
          @(posedge clk); #1;
          if (poke) begin
            req_valid = 1'b1;
            req_addr  = $urandom;
          end
          @(negedge clk);
          stable &= rsp_valid && ({rsp_error, rsp_data} === er) && !req_ready;
        end
        if (stall > 0) check("backpressure_hold", stable, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
      end else if (miss_valid) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(posedge clk); #1;
        miss_done = 1'b1;
        att++;
        way_hit = hv_q[(att < hv_q.size()) ? att : hv_q.size() - 1];
        @(posedge clk); #1;
        miss_done = 1'b0;
      end
    end
    if (!got_rsp) fail_now("rsp_timeout");
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (miss_valid && !prev_miss) begin
        if (exp_miss_q.size() == 0) fail_now("unexpected_miss");
        else check("miss_addr", miss_addr, exp_miss_q.pop_front());
      end
      if (target_way != '0) begin
        if (exp_tw_q.size() == 0) fail_now("unexpected_target_way");
        else check("target_way", target_way, exp_tw_q.pop_front());
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp_q.size() == 0) fail_now("unexpected_rsp");
        else check("rsp_err_data", {rsp_error, rsp_data}, exp_rsp_q.pop_front());
      end
    end
    prev_miss = miss_valid;
  end

  // ---------------- stimulus ----------------
  initial begin
    int waited;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    way_hit   = '0;
    read_data = '0;
    rsp_ready = 1'b0;
    miss_done = 1'b0;
`ifdef READ_STATS_EN
    stat_clr  = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", req_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_miss_valid", miss_valid, 0);
    check("reset_target_way", target_way, 0);
    check("reset_rsp", {rsp_error, rsp_data}, 0);
    rst_n = 1'b1;

    // Hit on way 7
    hv_q = '{bit_vec(7)};
    run_txn(32'h0000_1234, 32'hDEAD_BEEF, 0, 0);
    // Miss, refill, then hit on way 3
    hv_q = '{'0, bit_vec(3)};
    run_txn(32'h0000_1234, 32'hCAFE_F00D, 0, 0);
    // Persistent miss exhausts the refill budget
    hv_q = '{'0};
    run_txn(32'h0000_5678, 32'h1111_2222, 0, 0);
    // Multi-hit
    hv_q = '{bit_vec(0) | bit_vec(511)};
    run_txn(32'h0000_9ABC, 32'h3333_4444, 0, 0);
    // Backpressure with a competing request
    hv_q = '{bit_vec(100)};
    run_txn(32'hABCD_0010, 32'h5555_6666, 10, 1);

    // Reset while a refill is outstanding
    hv_q = '{'0};
    exp_miss_q.push_back(32'h0000_4440);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_addr  = 32'h0000_444C;
    way_hit   = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    waited = 0;
    @(negedge clk);
    while (!miss_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!miss_valid) fail_now("reset_test_miss_timeout");
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_miss_valid", miss_valid, 0);
    check("async_reset_req_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_req_ready", req_ready, 1);
    @(posedge clk); #1;
    miss_done = 1'b1;
    @(posedge clk); #1;
    miss_done = 1'b0;
    @(negedge clk);
    check("stray_done_miss_valid", miss_valid, 0);
    check("stray_done_idle", {req_ready, rsp_valid}, 2'b10);
`ifdef READ_STATS_EN
    mdl_hits = 0;
    mdl_misses = 0;
    mdl_errs = 0;
`endif

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      int n;
      hv_q.delete();
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        int r;
        r = $urandom_range(0, 9);
        hv_q.push_back(rand_hv((r < 4) ? 0 : (r < 8) ? 1 : 2));
      end
      run_txn($urandom, $urandom, $urandom_range(0, 4), $urandom_range(0, 1) == 1);
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rsp_queue_drained", exp_rsp_q.size(), 0);
    check("miss_queue_drained", exp_miss_q.size(), 0);
    check("target_queue_drained", exp_tw_q.size(), 0);
`ifdef READ_STATS_EN
    check("stat_hits", stat_hits, mdl_hits);
    check("stat_misses", stat_misses, mdl_misses);
    check("stat_errors", stat_errors, mdl_errs);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
